// File: rtl/ok_trig_pkg.sv
// ok_trig_pkg
// Shared constants and helpers for the trigger-in array.
//   TRIG_PULSE / TRIG_STICKY / TRIG_STRETCH : output mode selectors
//   clog2(n) : bits needed to hold values 0..n-1 (minimum 1)
package ok_trig_pkg;

  localparam int TRIG_PULSE   = 32'sd0;
  localparam int TRIG_STICKY  = 32'sd1;
  localparam int TRIG_STRETCH = 32'sd2;

  // Ceiling log2, never less than one bit so counters stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < n) begin
      r = r + 32'sd1;
    end
    if (r < 32'sd1) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/ok_trigger_bit.sv
// ok_trigger_bit
// Single-bit output stage: pulse flop, sticky flop or stretch counter,
// plus a sticky overrun flag.
// Ports:
//   ep_clk, ep_reset_n : clock, async active-low reset
//   fire               : pending bit released this cycle
//   ack                : consumer clear (sticky mode only)
//   clr                : overrun clear strobe for this bit
//   trigger            : registered trigger output
//   overrun            : registered overrun flag
module ok_trigger_bit
  import ok_trig_pkg::*;
#(
  parameter int MODE    = TRIG_PULSE,
  parameter int STRETCH = 32'sd4
) (
  input  logic ep_clk,
  input  logic ep_reset_n,
  input  logic fire,
  input  logic ack,
  input  logic clr,
  output logic trigger,
  output logic overrun
);

  localparam int            CW       = clog2(STRETCH + 32'sd1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  // Pulse outputs are never "already high" in a meaningful sense.
  localparam logic          OVR_EN   = (MODE != TRIG_PULSE);

  logic          trig_r;
  logic          ovr_r;
  logic [CW-1:0] cnt_r;
  logic          ovr_set_s;

  assign ovr_set_s = OVR_EN & fire & trig_r;

  // Output stage: per-mode trigger flop and stretch counter.
  always_ff @(posedge ep_clk or negedge ep_reset_n) begin
    if (!ep_reset_n) begin
      trig_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else begin
      case (MODE)
        TRIG_STICKY: begin
          // set wins over a coincident ack
          trig_r <= fire | (trig_r & ~ack);
          cnt_r  <= {CW{1'b0}};
        end
        TRIG_STRETCH: begin
          if (fire) begin
            cnt_r <= CNT_LOAD;
          end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= {CW{1'b0}};
          end
          // registered copy of "counter nonzero after this edge"
          trig_r <= fire | (cnt_r > CNT_ONE);
        end
        default: begin
          trig_r <= fire;
          cnt_r  <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Overrun flag: set on fire while high, set wins over clear.
  always_ff @(posedge ep_clk or negedge ep_reset_n) begin
    if (!ep_reset_n) begin
      ovr_r <= 1'b0;
    end else begin
      ovr_r <= ovr_set_s | (ovr_r & ~clr);
    end
  end

  assign trigger = trig_r;
  assign overrun = ovr_r;

endmodule

// File: rtl/ok_trigger_in_array.sv
// ok_trigger_in_array
// NUM_EP trigger-in endpoints at consecutive host addresses, WIDTH bits
// each, with per-endpoint hold and per-bit overrun detection.
// Ports:
//   ep_clk, ep_reset_n : clock, async active-low reset
//   ti_write, ti_addr, ti_datain : host write strobe / address / bit mask
//   ep_hold    : per endpoint, freeze pending -> output transfer
//   ep_ack     : per-bit clear for sticky mode
//   ep_trigger : trigger outputs, endpoint k at [k*WIDTH +: WIDTH]
//   ep_overrun : sticky per-bit overrun flags
//   ep_busy    : endpoint has pending or active output bits
module ok_trigger_in_array
  import ok_trig_pkg::*;
#(
  parameter int         WIDTH     = 32'sd16,
  parameter int         NUM_EP    = 32'sd4,
  parameter logic [7:0] BASE_ADDR = 8'h40,
  parameter int         MODE      = TRIG_PULSE,
  parameter int         STRETCH   = 32'sd4
) (
  input  logic                    ep_clk,
  input  logic                    ep_reset_n,
  input  logic                    ti_write,
  input  logic [7:0]              ti_addr,
  input  logic [WIDTH-1:0]        ti_datain,
  input  logic [NUM_EP-1:0]       ep_hold,
  input  logic [NUM_EP*WIDTH-1:0] ep_ack,
  output logic [NUM_EP*WIDTH-1:0] ep_trigger,
  output logic [NUM_EP*WIDTH-1:0] ep_overrun,
  output logic [NUM_EP-1:0]       ep_busy
);

  localparam logic [7:0] CLR_ADDR = 8'(BASE_ADDR + 8'(NUM_EP));

  logic             clr_hit_s;
  logic [WIDTH-1:0] clr_mask_s;

  // The clear mask applies to the same bit index in every endpoint.
  assign clr_hit_s  = ti_write & (ti_addr == CLR_ADDR);
  assign clr_mask_s = clr_hit_s ? ti_datain : {WIDTH{1'b0}};

  for (genvar k = 0; k < NUM_EP; k++) begin : g_ep
    localparam logic [7:0] EP_ADDR = 8'(BASE_ADDR + 8'(k));

    logic             hit_s;
    logic [WIDTH-1:0] hit_data_s;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] fire_s;

    assign hit_s      = ti_write & (ti_addr == EP_ADDR);
    assign hit_data_s = hit_s ? ti_datain : {WIDTH{1'b0}};

    // Pending accumulates while held; on transfer it reloads with any
    // same-cycle hit so that write is not lost.
    always_ff @(posedge ep_clk or negedge ep_reset_n) begin
      if (!ep_reset_n) begin
        pending_r <= {WIDTH{1'b0}};
      end else if (ep_hold[k]) begin
        pending_r <= pending_r | hit_data_s;
      end else begin
        pending_r <= hit_data_s;
      end
    end

    assign fire_s     = ep_hold[k] ? {WIDTH{1'b0}} : pending_r;
    assign ep_busy[k] = (|pending_r) | (|ep_trigger[k*WIDTH +: WIDTH]);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ok_trigger_bit #(
        .MODE    (MODE),
        .STRETCH (STRETCH)
      ) u_bit (
        .ep_clk     (ep_clk),
        .ep_reset_n (ep_reset_n),
        .fire       (fire_s[i]),
        .ack        (ep_ack[k*WIDTH + i]),
        .clr        (clr_mask_s[i]),
        .trigger    (ep_trigger[k*WIDTH + i]),
        .overrun    (ep_overrun[k*WIDTH + i])
      );
    end
  end

endmodule

// File: tb/tb_ok_trigger_in_array.sv
// tb_ok_trigger_in_array
// Drives three instances (pulse, sticky, stretch) from shared inputs and
// compares all outputs every cycle against a behavioural model kept here.
module tb_ok_trigger_in_array;
  import ok_trig_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int NB = W * N;
  localparam int ST = 4;
  localparam logic [7:0] BASE  = 8'h40;
  localparam logic [7:0] CLR_A = 8'h44;

  logic          ep_clk = 1'b0;
  logic          ep_reset_n = 1'b0;
  logic          ti_write = 1'b0;
  logic [7:0]    ti_addr = 8'h00;
  logic [W-1:0]  ti_datain = '0;
  logic [N-1:0]  ep_hold = '0;
  logic [NB-1:0] ep_ack = '0;

  logic [NB-1:0] trig_p, trig_s, trig_t, ovr_p, ovr_s, ovr_t;
  logic [N-1:0]  busy_p, busy_s, busy_t;

  always #5 ep_clk = ~ep_clk;

  ok_trigger_in_array #(.WIDTH(W), .NUM_EP(N), .BASE_ADDR(BASE), .MODE(TRIG_PULSE), .STRETCH(ST)) u_dut_pulse (
    .ep_clk(ep_clk), .ep_reset_n(ep_reset_n), .ti_write(ti_write), .ti_addr(ti_addr),
    .ti_datain(ti_datain), .ep_hold(ep_hold), .ep_ack(ep_ack),
    .ep_trigger(trig_p), .ep_overrun(ovr_p), .ep_busy(busy_p));

  ok_trigger_in_array #(.WIDTH(W), .NUM_EP(N), .BASE_ADDR(BASE), .MODE(TRIG_STICKY), .STRETCH(ST)) u_dut_sticky (
    .ep_clk(ep_clk), .ep_reset_n(ep_reset_n), .ti_write(ti_write), .ti_addr(ti_addr),
    .ti_datain(ti_datain), .ep_hold(ep_hold), .ep_ack(ep_ack),
    .ep_trigger(trig_s), .ep_overrun(ovr_s), .ep_busy(busy_s));

  ok_trigger_in_array #(.WIDTH(W), .NUM_EP(N), .BASE_ADDR(BASE), .MODE(TRIG_STRETCH), .STRETCH(ST)) u_dut_stretch (
    .ep_clk(ep_clk), .ep_reset_n(ep_reset_n), .ti_write(ti_write), .ti_addr(ti_addr),
    .ti_datain(ti_datain), .ep_hold(ep_hold), .ep_ack(ep_ack),
    .ep_trigger(trig_t), .ep_overrun(ovr_t), .ep_busy(busy_t));

  int checks = 0;
  int errors = 0;

  // Model state: pending per endpoint, sticky set, overrun sets, and the
  // edge number of the most recent fire per bit (stretch = "fired less than
  // ST edges ago").
  logic [W-1:0]  m_pend [N];
  logic [NB-1:0] m_pulse, m_sticky, m_ovr_s, m_ovr_t;
  int            m_last [NB];
  int            m_cyc;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_pend[k] = '0;
    for (int b = 0; b < NB; b++) m_last[b] = -1000;
    m_pulse = '0; m_sticky = '0; m_ovr_s = '0; m_ovr_t = '0;
    m_cyc = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [NB-1:0] str;
    logic [N-1:0]  bp, bs, bt;
    for (int b = 0; b < NB; b++) str[b] = (m_cyc - m_last[b]) < ST;
    for (int k = 0; k < N; k++) begin
      bp[k] = (|m_pend[k]) | (|m_pulse[k*W +: W]);
      bs[k] = (|m_pend[k]) | (|m_sticky[k*W +: W]);
      bt[k] = (|m_pend[k]) | (|str[k*W +: W]);
    end
    check_val({tag, ".trig_p"}, trig_p, m_pulse);
    check_val({tag, ".trig_s"}, trig_s, m_sticky);
    check_val({tag, ".trig_t"}, trig_t, str);
    check_val({tag, ".ovr_p"}, ovr_p, 64'h0);
    check_val({tag, ".ovr_s"}, ovr_s, m_ovr_s);
    check_val({tag, ".ovr_t"}, ovr_t, m_ovr_t);
    check_val({tag, ".busy_p"}, 64'(busy_p), 64'(bp));
    check_val({tag, ".busy_s"}, 64'(busy_s), 64'(bs));
    check_val({tag, ".busy_t"}, 64'(busy_t), 64'(bt));
  endtask

  // Called just after a negedge with inputs set; models the next rising
  // edge, checks #1 after it and returns at the following negedge.
  task automatic step(input string tag);
    logic [NB-1:0] fire, old_str, clr;
    logic [W-1:0]  hd;
    logic [7:0]    a;
    fire = '0;
    clr  = '0;
    for (int k = 0; k < N; k++) begin
      if (!ep_hold[k]) fire[k*W +: W] = m_pend[k];
      if (ti_write && ti_addr == CLR_A) clr[k*W +: W] = ti_datain;
    end
    for (int b = 0; b < NB; b++) old_str[b] = (m_cyc - m_last[b]) < ST;
    m_ovr_s  = (m_ovr_s & ~clr) | (fire & m_sticky);
    m_ovr_t  = (m_ovr_t & ~clr) | (fire & old_str);
    m_sticky = fire | (m_sticky & ~ep_ack);
    m_pulse  = fire;
    m_cyc++;
    for (int b = 0; b < NB; b++) if (fire[b]) m_last[b] = m_cyc;
    for (int k = 0; k < N; k++) begin
      a  = BASE + 8'(k);
      hd = (ti_write && ti_addr == a) ? ti_datain : '0;
      m_pend[k] = ep_hold[k] ? (m_pend[k] | hd) : hd;
    end
    @(posedge ep_clk);
    #1;
    check_outputs(tag);
    @(negedge ep_clk);
  endtask

  task automatic drive(input string tag, input logic wr, input logic [7:0] ad, input logic [W-1:0] d,
                       input logic [N-1:0] h, input logic [NB-1:0] ack);
    ti_write = wr; ti_addr = ad; ti_datain = d; ep_hold = h; ep_ack = ack;
    step(tag);
  endtask

  // Reset asserted between edges; outputs must drop before any edge.
  task automatic do_reset();
    ti_write = 1'b0; ti_addr = 8'h00; ti_datain = '0; ep_hold = '0; ep_ack = '0;
    #2;
    ep_reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge ep_clk);
    ep_reset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    model_reset();
    #2;
    check_outputs("rst0");
    @(negedge ep_clk);
    ep_reset_n = 1'b1;

    // pulse with defaults: one-cycle 0x0005 on endpoint 1 two edges later
    drive("pulse", 1'b1, 8'h41, 16'h0005, 4'h0, '0);
    check_val("pulse_early", 64'(trig_p[16 +: 16]), 64'h0);
    drive("pulse", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
    check_val("pulse_hi", 64'(trig_p[16 +: 16]), 64'h0005);
    drive("pulse", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
    check_val("pulse_lo", 64'(trig_p[16 +: 16]), 64'h0);

    // hold accumulation on endpoint 2
    drive("hold", 1'b1, 8'h42, 16'h0001, 4'b0100, '0);
    check_val("hold_busy", 64'(busy_p[2]), 64'h1);
    drive("hold", 1'b1, 8'h42, 16'h0100, 4'b0100, '0);
    check_val("hold_busy", 64'(busy_p[2]), 64'h1);
    drive("hold", 1'b0, 8'h00, 16'h0000, 4'b0100, '0);
    check_val("hold_busy", 64'(busy_p[2]), 64'h1);
    check_val("hold_quiet", 64'(trig_p[32 +: 16]), 64'h0);
    drive("hold", 1'b0, 8'h00, 16'h0000, 4'b0000, '0);
    check_val("hold_fire", 64'(trig_p[32 +: 16]), 64'h0101);
    drive("hold", 1'b0, 8'h00, 16'h0000, 4'b0000, '0);
    check_val("hold_done", 64'(trig_p[32 +: 16]), 64'h0);

    // sticky: re-fire bit 3 of endpoint 0 on the same cycle as its ack
    drive("stk", 1'b1, 8'h40, 16'h0008, 4'h0, '0);
    drive("stk", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
    drive("stk", 1'b1, 8'h40, 16'h0008, 4'h0, '0);
    drive("stk", 1'b0, 8'h00, 16'h0000, 4'h0, 64'h8);
    check_val("stk_setwin", 64'(trig_s[3]), 64'h1);
    check_val("stk_ovr", 64'(ovr_s[3]), 64'h1);
    drive("stk", 1'b0, 8'h00, 16'h0000, 4'h0, 64'h8);
    check_val("stk_ack", 64'(trig_s[3]), 64'h0);
    check_val("stk_ovr_keep", 64'(ovr_s[3]), 64'h1);
    drive("stk", 1'b1, 8'h44, 16'h0008, 4'h0, '0);
    check_val("stk_ovr_clr", 64'(ovr_s[3]), 64'h0);

    // stretch retrigger: fires two edges apart -> six high cycles
    do_reset();
    cnt = 0;
    drive("str", 1'b1, 8'h40, 16'h0001, 4'h0, '0); cnt += int'(trig_t[0]);
    drive("str", 1'b0, 8'h00, 16'h0000, 4'h0, '0); cnt += int'(trig_t[0]);
    drive("str", 1'b1, 8'h40, 16'h0001, 4'h0, '0); cnt += int'(trig_t[0]);
    drive("str", 1'b0, 8'h00, 16'h0000, 4'h0, '0); cnt += int'(trig_t[0]);
    for (int j = 0; j < 8; j++) begin
      drive("str", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
      cnt += int'(trig_t[0]);
    end
    check_val("str_len", 64'(cnt), 64'd6);
    check_val("str_ovr", 64'(ovr_t[0]), 64'h1);

    // out-of-range addresses
    do_reset();
    drive("range", 1'b1, 8'h3F, 16'hFFFF, 4'h0, '0);
    drive("range", 1'b1, 8'h45, 16'hFFFF, 4'h0, '0);
    drive("range", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
    check_val("range_busy", 64'({busy_p, busy_s, busy_t}), 64'h0);
    check_val("range_trig", trig_p | trig_s | trig_t, 64'h0);

    // reset mid-stretch, then no residual activity
    drive("rms", 1'b1, 8'h40, 16'hFFFF, 4'h0, '0);
    drive("rms", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
    drive("rms", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
    do_reset();
    for (int j = 0; j < 6; j++) begin
      drive("rms", 1'b0, 8'h00, 16'h0000, 4'h0, '0);
      check_val("rms_quiet", trig_p | trig_s | trig_t, 64'h0);
    end

    // randomized traffic around the address window
    for (int j = 0; j < 1500; j++) begin
      logic [N-1:0] h;
      for (int k = 0; k < N; k++) h[k] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive("rnd", ($urandom_range(0, 2) != 0), 8'(8'h3E + 8'($urandom_range(0, 8))),
              W'($urandom), h, {$urandom, $urandom} & {$urandom, $urandom});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ok_trigger_in_array.md
# ok_trigger_in_array

Parametrised successor to the single trigger-in endpoint. It serves NUM_EP consecutive host addresses, each WIDTH bits wide, all in one clock domain. Each bit can deliver a one-cycle pulse, a sticky level cleared by the consumer, or a stretched pulse. The block adds a per-endpoint hold (pending accumulation) and per-bit overrun detection. It sits between the host write bus decode and the user logic consuming triggers.

## Interface
Parameters:
- WIDTH, 16, bits per endpoint (1..32)
- NUM_EP, 4, number of endpoints (1..16)
- BASE_ADDR, 8'h40, address of endpoint 0; endpoint k at BASE_ADDR+k; overrun-clear register at BASE_ADDR+NUM_EP
- MODE, 0, output mode for all bits: 0 pulse, 1 sticky, 2 stretch
- STRETCH, 4, stretch length in cycles (MODE 2 only, 1..255)

Ports:
- ep_clk  in  1  sole clock, all state on rising edge
- ep_reset_n  in  1  asynchronous, active-low reset
- ti_write  in  1  host write strobe, one cycle per write
- ti_addr  in  8  host write address
- ti_datain  in  WIDTH  host write data (bit mask)
- ep_hold  in  NUM_EP  per-endpoint: freeze transfer of pending to output
- ep_ack  in  NUM_EP*WIDTH  per-bit clear in sticky mode (ignored otherwise)
- ep_trigger  out  NUM_EP*WIDTH  trigger outputs, endpoint k at [k*WIDTH +: WIDTH]
- ep_overrun  out  NUM_EP*WIDTH  sticky per-bit overrun flags
- ep_busy  out  NUM_EP  endpoint k has any pending bit or any output bit active

## Operation
- Address hit: ti_write=1 and ti_addr==BASE_ADDR+k. Addresses outside the block's range are ignored.
- pending[k]: on hit, pending |= ti_datain. On a transfer edge (ep_hold[k]=0), pending <= (hit ? ti_datain : 0). A hit on the transfer edge is therefore never lost.
- fire[k] = pending[k] when ep_hold[k]=0, else 0.
- Pulse mode: ep_trigger bit = fire bit for exactly one cycle.
- Sticky mode: a bit is set by fire and cleared by the matching ep_ack bit. When set and ack coincide, set wins.
- Stretch mode: fire loads the per-bit counter with STRETCH. The output is high while the counter is nonzero, and the counter decrements each cycle. A re-fire while nonzero reloads STRETCH.
- Overrun: a fire on a bit whose output is already high (sticky or stretch) sets the ep_overrun bit. A pulse-mode fire on a bit still in pending while held does not count as overrun. Overrun clears only on reset or a write to the clear address: ep_overrun[k*WIDTH+i] clears where ti_datain[i]=1, for all k. If a clear and a set coincide, set wins.
- ep_busy[k] = |pending[k] | |ep_trigger[k] (registered-derived, combinational OR).

## Timing
- Reset (asynchronous assert, synchronous release on next edge): pending, counters, ep_trigger, and ep_overrun are all 0.
- Latency: hit at edge N sets pending; ep_trigger rises after edge N+1. Total: 2 edges from write to output.
- Back-to-back hits on consecutive cycles produce pulses on consecutive cycles with no loss.
- Hold: pending accumulates (OR) across any number of hits. Releasing ep_hold at edge M fires at edge M+1.
- Stretch: the output is high for exactly STRETCH cycles after a single fire.
- Reset mid-stretch or mid-hold: all state is discarded, with no residual pulse after release.

## Structure
- Package ok_trig_pkg: mode constants TRIG_PULSE=0, TRIG_STICKY=1, TRIG_STRETCH=2, and the counter-width function clog2.
- Sub-module ok_trigger_bit: a single-bit output stage (sticky flop or stretch counter, plus overrun flop), instantiated NUM_EP*WIDTH times via generate. The top level holds the address decode, the pending registers, and the clear-address logic.

## Test plan
- Pulse, defaults: write 16'h0005 to 8'h41 at edge N. Required: ep_trigger[16+:16]=16'h0005 for exactly one cycle after edge N+1, then 0.
- Hold accumulation: ep_hold[2]=1; write 16'h0001, then 16'h0100 to 8'h42; release hold. Required: a single 16'h0101 pulse one edge after release, and ep_busy[2]=1 throughout the hold.
- Sticky with ack race: MODE=1, fire bit 3 of endpoint 0, then fire it again on the same cycle ep_ack bit 3 is asserted. Required: the bit stays 1 and ep_overrun bit 3 is 1. A later ack alone clears the trigger; the overrun persists until a write of 16'h0008 to 8'h44 clears it.
- Stretch retrigger: MODE=2, STRETCH=4, fire bit 0, then re-fire 2 cycles later. Required: the output is high for 6 consecutive cycles and ep_overrun bit 0 is set.
- Address range: write to 8'h3F and 8'h45 (clear address = 8'h44). Required: no trigger, no overrun change, ep_busy=0.
- Async reset mid-stretch: assert ep_reset_n=0 between edges. Required: all outputs go to 0 immediately, and no output activity follows release.
